// File: rtl/conv3x3_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution controller.
// Purpose : holds the controller state encoding and the window tap count so
//           the top level and any future companions agree on them.
// Contents: state_e    - controller FSM states
//           WIN_TAPS   - number of taps in the 3x3 window (and weights)
//           PIX_W      - width of one signed weight byte
//           WIDX_W     - width of the weight slot index
package conv_pkg;

   localparam int WIN_TAPS = 9;
   localparam int PIX_W    = 8;
   localparam int WIDX_W   = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      RUN    = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/conv3x3_ctrl_raster_cnt.sv
// raster_cnt - row/column position counter for a raster-scanned image.
// Purpose : tracks the (row, col) coordinate of the next pixel to arrive.
//           Column wraps at IMG_W-1 and bumps the row; the row wraps at the
//           last line so the counter is back at (0,0) after a full frame.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           en    - advance one pixel position
//           col   - current column, $clog2(IMG_W) bits
//           row   - current row, $clog2(IMG_H) bits
//           last  - current position is the final pixel of the frame
module raster_cnt #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   output logic [$clog2(IMG_W)-1:0] col,
   output logic [$clog2(IMG_H)-1:0] row,
   output logic                     last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          colEnd;
   logic          rowEnd;

   assign colEnd = (col_q == CW'(IMG_W - 1));
   assign rowEnd = (row_q == RW'(IMG_H - 1));

   // Next position: hold while disabled, otherwise step along the raster
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (en) begin
         if (colEnd) begin
            col_d = '0;
            row_d = rowEnd ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Position registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign last = colEnd && rowEnd;

endmodule

// File: rtl/conv3x3_ctrl.sv
// conv3x3_ctrl - sequencing controller for an external 3x3 MAC + line buffers.
// Purpose : loads nine signed weights, accepts one frame of pixels, and
//           tells the MAC when a full 3x3 window is present. Two cycles of
//           drain cover the MAC's input and output register stages.
// Ports   : clk          - clock
//           rst_n        - asynchronous active-low reset
//           start        - begin a frame (only honoured in IDLE)
//           w_valid      - weight byte present on w_data
//           w_data       - signed weight, raster order 00 first
//           pix_valid    - upstream pixel present
//           pix_ready    - controller accepts pixels (high in RUN)
//           shift_en     - line buffer / window shift strobe (= transfer)
//           weight_flat  - nine weights, weight00 in [7:0]
//           mac_in_valid - window valid into the MAC
//           out_valid    - MAC output register holds a new result
//           busy         - controller not idle
//           done         - one-cycle end-of-frame pulse
module conv3x3_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        w_valid,
   input  logic [PIX_W-1:0]            w_data,
   input  logic                        pix_valid,
   output logic                        pix_ready,
   output logic                        shift_en,
   output logic [WIN_TAPS*PIX_W-1:0]   weight_flat,
   output logic                        mac_in_valid,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   state_e                       state_q, state_d;
   logic [WIDX_W-1:0]            wIdx_q, wIdx_d;
   logic [WIN_TAPS*PIX_W-1:0]    weights_q, weights_d;
   logic                         drainCnt_q, drainCnt_d;
   logic                         macValid_q, macValid_d;
   logic                         outValid_q;

   logic                         transfer;
   logic [CW-1:0]                col;
   logic [RW-1:0]                row;
   logic                         lastPix;

   assign transfer = (state_q == RUN) && pix_valid;

   raster_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_raster_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (transfer),
      .col   (col),
      .row   (row),
      .last  (lastPix)
   );

   // Next-state logic. Weights are only written in LOAD_W, so they hold
   // their values from the end of one load until the next load begins.
   always_comb begin
      state_d    = state_q;
      wIdx_d     = wIdx_q;
      weights_d  = weights_q;
      drainCnt_d = drainCnt_q;
      unique case (state_q)
         IDLE: begin
            wIdx_d = '0;
            if (start) begin
               state_d = LOAD_W;
            end
         end
         LOAD_W: begin
            if (w_valid) begin
               for (int i = 0; i < WIN_TAPS; i++) begin
                  if (wIdx_q == WIDX_W'(i)) begin
                     weights_d[i*PIX_W +: PIX_W] = w_data;
                  end
               end
               if (wIdx_q == WIDX_W'(WIN_TAPS - 1)) begin
                  wIdx_d  = '0;
                  state_d = RUN;
               end else begin
                  wIdx_d = wIdx_q + WIDX_W'(1);
               end
            end
         end
         RUN: begin
            drainCnt_d = 1'b0;
            if (transfer && lastPix) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            drainCnt_d = 1'b1;
            if (drainCnt_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A window is complete once the accepted pixel sits at row>=2, col>=2;
   // the coordinates used are those of the pixel being transferred.
   always_comb begin
      macValid_d = transfer && (row >= RW'(2)) && (col >= CW'(2));
   end

   // State and datapath-control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wIdx_q     <= '0;
         weights_q  <= '0;
         drainCnt_q <= 1'b0;
         macValid_q <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wIdx_q     <= wIdx_d;
         weights_q  <= weights_d;
         drainCnt_q <= drainCnt_d;
         macValid_q <= macValid_d;
         outValid_q <= macValid_q;
      end
   end

   assign pix_ready    = (state_q == RUN);
   assign shift_en     = transfer;
   assign weight_flat  = weights_q;
   assign mac_in_valid = macValid_q;
   assign out_valid    = outValid_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Directed testbench for conv3x3_ctrl: a 4x4 instance exercises streaming,
// stalls, stray start/weight strobes and mid-frame reset; a 5x3 instance
// exercises a non-square frame.
module tb_conv3x3_ctrl;

   logic        clk;
   logic        rst_n;

   logic        start, wValid, pixValid;
   logic [7:0]  wData;
   logic        pixReady, shiftEn, macInValid, outValid, busy, done;
   logic [71:0] weightFlat;

   logic        start2, wValid2, pixValid2;
   logic [7:0]  wData2;
   logic        pixReady2, shiftEn2, macInValid2, outValid2, busy2, done2;
   logic [71:0] weightFlat2;

   int checks = 0;
   int errors = 0;
   int ovCount = 0;
   int ovCount2 = 0;

   localparam logic [71:0] W19 = 72'h09_08_07_06_05_04_03_02_01;

   conv3x3_ctrl #(.IMG_W(4), .IMG_H(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .w_valid      (wValid),
      .w_data       (wData),
      .pix_valid    (pixValid),
      .pix_ready    (pixReady),
      .shift_en     (shiftEn),
      .weight_flat  (weightFlat),
      .mac_in_valid (macInValid),
      .out_valid    (outValid),
      .busy         (busy),
      .done         (done)
   );

   conv3x3_ctrl #(.IMG_W(5), .IMG_H(3)) dut53 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start2),
      .w_valid      (wValid2),
      .w_data       (wData2),
      .pix_valid    (pixValid2),
      .pix_ready    (pixReady2),
      .shift_en     (shiftEn2),
      .weight_flat  (weightFlat2),
      .mac_in_valid (macInValid2),
      .out_valid    (outValid2),
      .busy         (busy2),
      .done         (done2)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count out_valid cycles of both instances
   always @(posedge clk) begin
      if (outValid === 1'b1) ovCount++;
      if (outValid2 === 1'b1) ovCount2++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit isWin(input int p, input int w);
      return ((p / w) >= 2) && ((p % w) >= 2);
   endfunction

   // Start a frame on the 4x4 instance and load weights 1..9
   task automatic applyStimulus();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("busy_in_load", busy, 1);
      checkOutput("ready_in_load", pixReady, 0);
      for (int i = 0; i < 9; i++) begin
         wValid = 1'b1;
         wData  = 8'(i + 1);
         tick();
      end
      wValid = 1'b0;
      checkOutput("weights_loaded", weightFlat, W19);
      checkOutput("ready_in_run", pixReady, 1);
   endtask

   // Stream one 4x4 frame, optionally stalling between pixels, poking start
   // in RUN and DONE, or driving stray weights during RUN
   task automatic runFrame(input bit stall, input bit pokeStart, input bit pokeWeight);
      int  base;
      bit  lastMac;
      base    = ovCount;
      lastMac = 1'b0;
      applyStimulus();
      for (int p = 0; p < 16; p++) begin
         pixValid = 1'b1;
         if (pokeWeight) begin
            wValid = 1'b1;
            wData  = 8'h7F;
         end
         if (pokeStart && p == 5) start = 1'b1;
         if (p == 0) begin
            #1;
            checkOutput("shift_en_on_transfer", shiftEn, 1);
         end
         tick();
         start = 1'b0;
         checkOutput($sformatf("out_valid_p%0d", p), outValid, lastMac);
         lastMac = isWin(p, 4);
         checkOutput($sformatf("mac_in_valid_p%0d", p), macInValid, lastMac);
         if (pokeStart && p == 5) checkOutput("busy_after_start_in_run", busy, 1);
         if (stall && p < 15) begin
            pixValid = 1'b0;
            #1;
            checkOutput("shift_en_in_stall", shiftEn, 0);
            tick();
            checkOutput($sformatf("out_valid_stall%0d", p), outValid, lastMac);
            lastMac = 1'b0;
            checkOutput($sformatf("mac_after_stall%0d", p), macInValid, 0);
         end
      end
      pixValid = 1'b0;
      wValid   = 1'b0;
      checkOutput("ready_in_drain", pixReady, 0);
      tick();
      checkOutput("out_valid_drain2", outValid, 1);
      checkOutput("done_in_drain", done, 0);
      tick();
      checkOutput("done_pulse", done, 1);
      checkOutput("busy_in_done", busy, 1);
      checkOutput("out_valid_in_done", outValid, 0);
      checkOutput("frame_pulses", 72'(ovCount - base), 72'd4);
      checkOutput("weights_after_frame", weightFlat, W19);
      if (pokeStart) start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("idle_after_done", busy, 0);
      checkOutput("done_cleared", done, 0);
      tick();
      checkOutput("start_in_done_ignored", busy, 0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      start = 1'b0; wValid = 1'b0; wData = 8'h00; pixValid = 1'b0;
      start2 = 1'b0; wValid2 = 1'b0; wData2 = 8'h00; pixValid2 = 1'b0;
      tick();
      tick();
      checkOutput("rst_weights", weightFlat, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ready", pixReady, 0);
      checkOutput("rst_shift", shiftEn, 0);
      checkOutput("rst_mac", macInValid, 0);
      checkOutput("rst_out", outValid, 0);
      checkOutput("rst_done", done, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] back-to-back frame");
      runFrame(1'b0, 1'b0, 1'b0);
      $display("[TB] stalled frame");
      runFrame(1'b1, 1'b0, 1'b0);
      $display("[TB] stray start and weight strobes");
      runFrame(1'b0, 1'b1, 1'b1);

      $display("[TB] mid-frame reset");
      applyStimulus();
      for (int p = 0; p < 7; p++) begin
         pixValid = 1'b1;
         tick();
      end
      base  = ovCount;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_weights", weightFlat, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_ready", pixReady, 0);
      checkOutput("abort_shift", shiftEn, 0);
      checkOutput("abort_mac", macInValid, 0);
      checkOutput("abort_out", outValid, 0);
      checkOutput("abort_done", done, 0);
      tick();
      tick();
      pixValid = 1'b0;
      rst_n    = 1'b1;
      tick();
      tick();
      checkOutput("abort_no_pulses", 72'(ovCount - base), 72'd0);
      checkOutput("abort_stays_idle", busy, 0);
      runFrame(1'b0, 1'b0, 1'b0);

      $display("[TB] 5x3 frame");
      base   = ovCount2;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wValid2 = 1'b1;
         wData2  = 8'(9 - i);
         tick();
      end
      wValid2 = 1'b0;
      checkOutput("w53_weights", weightFlat2, 72'h01_02_03_04_05_06_07_08_09);
      for (int p = 0; p < 15; p++) begin
         pixValid2 = 1'b1;
         tick();
         checkOutput($sformatf("w53_mac_p%0d", p), macInValid2, 72'(isWin(p, 5)));
      end
      pixValid2 = 1'b0;
      checkOutput("w53_drain", pixReady2, 0);
      tick();
      checkOutput("w53_out_last", outValid2, 1);
      tick();
      checkOutput("w53_done", done2, 1);
      checkOutput("w53_pulses", 72'(ovCount2 - base), 72'd3);
      tick();
      checkOutput("w53_idle", busy2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
